// File: rtl/pulse_interval_meter.sv
// Measures clock-cycle intervals between single-cycle pulses and queues them
// in a first-word-fall-through FIFO that is drained over valid/ready.
module pulse_interval_meter #(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          pulse_in_i,
    output logic                          iv_valid_o,
    input  logic                          iv_ready_i,
    output logic [CNT_W:0]                iv_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    input  logic                          clr_ovf_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CW-1:0]    DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic [CNT_W:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               valid_q;
    logic               ovf_q, ovf_d;

    logic               pop;
    logic               push_req;
    logic               push_ok;

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    always_comb begin
        pop      = valid_q && iv_ready_i;
        push_req = (state_q == MEASURE) && enable_i && pulse_in_i;
        push_ok  = push_req && ((count_q < DEPTH_CNT) || pop);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pulse_in_i) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_W'(1);
                        sat_d   = 1'b0;
                    end
                end
                MEASURE: begin
                    if (pulse_in_i) begin
                        cnt_d = CNT_W'(1);
                        sat_d = 1'b0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_MAX - 1'b1) begin
                            sat_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A new drop outranks a same-cycle clear so no lost sample goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            ovf_q    <= ovf_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {sat_q, cnt_q};
            end
        end
    end

    assign iv_valid_o   = valid_q;
    assign iv_data_o    = mem_q[rd_ptr_q];
    assign fifo_count_o = count_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Directed bench for pulse_interval_meter, built with a 4-bit counter so
// saturation is reachable in a few dozen cycles.
module tb_pulse_interval_meter;

    localparam int CNT_W = 4;
    localparam int DEPTH = 4;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     enable_i;
    logic                     pulse_in_i;
    logic                     iv_valid_o;
    logic                     iv_ready_i;
    logic [CNT_W:0]           iv_data_o;
    logic [$clog2(DEPTH):0]   fifo_count_o;
    logic                     overflow_o;
    logic                     clr_ovf_i;

    int n_cmp = 0;
    int n_bad = 0;

    pulse_interval_meter #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .pulse_in_i   (pulse_in_i),
        .iv_valid_o   (iv_valid_o),
        .iv_ready_i   (iv_ready_i),
        .iv_data_o    (iv_data_o),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o),
        .clr_ovf_i    (clr_ovf_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Pulse lands gap edges after the previous one, giving an interval of gap.
    task automatic pulse_after(input int gap);
        if (gap > 1) step(gap - 1);
        pulse_in_i = 1'b1;
        step(1);
        pulse_in_i = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, 32'(iv_valid_o), 32'd1);
        check({tag, "_data"}, 32'(iv_data_o), exp);
    endtask

    initial begin
        rst_i      = 1'b1;
        enable_i   = 1'b0;
        pulse_in_i = 1'b0;
        iv_ready_i = 1'b0;
        clr_ovf_i  = 1'b0;
        step(2);
        rst_i = 1'b0;
        check("rst_valid", 32'(iv_valid_o), 0);
        check("rst_data", 32'(iv_data_o), 0);
        check("rst_count", 32'(fifo_count_o), 0);
        check("rst_ovf", 32'(overflow_o), 0);

        // basic intervals 5 and 12 with a ready consumer
        enable_i   = 1'b1;
        iv_ready_i = 1'b1;
        pulse_after(1);
        check("arm_count", 32'(fifo_count_o), 0);
        pulse_after(5);
        check_head("basic5", 5);
        check("basic5_count", 32'(fifo_count_o), 1);
        pulse_after(12);
        check_head("basic12", 12);
        step(1);
        check("basic_drained", 32'(iv_valid_o), 0);
        check("basic_count0", 32'(fifo_count_o), 0);

        // back-to-back pulses; the second push coincides with a pop
        enable_i = 1'b0;
        step(1);
        enable_i = 1'b1;
        pulse_after(1);
        pulse_after(1);
        check_head("b2b_first", 1);
        pulse_after(1);
        check_head("b2b_second", 1);
        check("b2b_count", 32'(fifo_count_o), 1);
        step(1);
        check("b2b_drained", 32'(iv_valid_o), 0);

        // saturation at 15 with sat flag, then a normal interval
        enable_i = 1'b0;
        step(1);
        enable_i = 1'b1;
        pulse_after(1);
        pulse_after(40);
        check_head("sat", 5'h1F);
        pulse_after(3);
        check_head("after_sat", 3);
        step(1);

        // overflow under backpressure; the clear loses to a coincident drop
        iv_ready_i = 1'b0;
        enable_i = 1'b0;
        step(1);
        enable_i = 1'b1;
        pulse_after(1);
        pulse_after(3);
        pulse_after(4);
        pulse_after(5);
        pulse_after(6);
        check("full_count", 32'(fifo_count_o), 4);
        check("full_noovf", 32'(overflow_o), 0);
        pulse_after(7);
        check("ovf_set", 32'(overflow_o), 1);
        check("ovf_count", 32'(fifo_count_o), 4);
        step(7);
        pulse_in_i = 1'b1;
        clr_ovf_i  = 1'b1;
        step(1);
        pulse_in_i = 1'b0;
        clr_ovf_i  = 1'b0;
        check("ovf_set_wins", 32'(overflow_o), 1);
        enable_i   = 1'b0;
        iv_ready_i = 1'b1;
        check_head("drain0", 3);
        step(1);
        check_head("drain1", 4);
        step(1);
        check_head("drain2", 5);
        step(1);
        check_head("drain3", 6);
        step(1);
        check("drain_empty", 32'(iv_valid_o), 0);
        check("drain_count", 32'(fifo_count_o), 0);
        check("ovf_sticky", 32'(overflow_o), 1);
        clr_ovf_i = 1'b1;
        step(1);
        clr_ovf_i = 1'b0;
        check("ovf_cleared", 32'(overflow_o), 0);

        // full FIFO, push and pop on the same edge
        iv_ready_i = 1'b0;
        enable_i   = 1'b1;
        pulse_after(1);
        pulse_after(2);
        pulse_after(3);
        pulse_after(4);
        pulse_after(5);
        check("fullpop_pre", 32'(fifo_count_o), 4);
        step(5);
        iv_ready_i = 1'b1;
        pulse_in_i = 1'b1;
        step(1);
        pulse_in_i = 1'b0;
        iv_ready_i = 1'b0;
        check("fullpop_count", 32'(fifo_count_o), 4);
        check("fullpop_ovf", 32'(overflow_o), 0);
        enable_i   = 1'b0;
        iv_ready_i = 1'b1;
        check_head("fp0", 3);
        step(1);
        check_head("fp1", 4);
        step(1);
        check_head("fp2", 5);
        step(1);
        check_head("fp3", 6);
        step(1);
        check("fp_empty", 32'(iv_valid_o), 0);

        // enable dropped mid-measurement; pulse during enable=0 ignored
        enable_i = 1'b1;
        pulse_after(1);
        step(2);
        enable_i   = 1'b0;
        pulse_in_i = 1'b1;
        step(1);
        pulse_in_i = 1'b0;
        check("en_off_nopush", 32'(iv_valid_o), 0);
        enable_i = 1'b1;
        step(3);
        pulse_in_i = 1'b1;
        step(1);
        pulse_in_i = 1'b0;
        check("rearm_nopush", 32'(fifo_count_o), 0);
        pulse_after(8);
        check_head("en_interval", 8);
        step(1);
        check("en_drained", 32'(iv_valid_o), 0);

        // reset with entries queued and a pulse/handshake pending
        iv_ready_i = 1'b0;
        pulse_after(2);
        pulse_after(3);
        check("prerst_count", 32'(fifo_count_o), 2);
        rst_i      = 1'b1;
        pulse_in_i = 1'b1;
        iv_ready_i = 1'b1;
        step(1);
        rst_i      = 1'b0;
        pulse_in_i = 1'b0;
        iv_ready_i = 1'b0;
        check("mrst_valid", 32'(iv_valid_o), 0);
        check("mrst_data", 32'(iv_data_o), 0);
        check("mrst_count", 32'(fifo_count_o), 0);
        check("mrst_ovf", 32'(overflow_o), 0);
        pulse_after(4);
        check("mrst_idle_arm", 32'(fifo_count_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_interval_meter.md
# pulse_interval_meter

Downstream consumer of the debounced pulse stage. Takes the clean single-cycle pulses it produces and measures the clock-cycle interval between successive pulses. Each interval goes into a small first-word-fall-through FIFO, which a register or readout stage drains over a valid/ready handshake. Saturation of the interval counter and FIFO overflow are flagged, not silently dropped.

## Interface
- CNT_W, 16: width of interval counter and of measured value.
- FIFO_DEPTH, 4: number of interval entries buffered; power of two, ≥2.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  measurement enable; low forces IDLE.
- pulse_in  input  1  single-cycle event pulse from the filter stage.
- iv_valid  output  1  FIFO head holds an entry.
- iv_ready  input  1  consumer accepts head when iv_valid && iv_ready.
- iv_data  output  CNT_W+1  {sat, interval}: bit CNT_W is saturation flag, low bits are cycle count.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; an interval was dropped because FIFO was full.
- clr_ovf  input  1  clears overflow (one cycle, synchronous).

## Operation
- Reset (rst=1 at edge): state=IDLE, counter=0, sat=0, FIFO empty, iv_valid=0, iv_data=0, fifo_count=0, overflow=0.
- FSM states: IDLE, MEASURE.
  - IDLE: counter held at 0. pulse_in && enable → MEASURE, counter←1, sat←0. No push.
  - MEASURE: each cycle without pulse, counter increments, saturating at 2^CNT_W−1; reaching max sets sat←1. On pulse_in: push {sat, counter}, then counter←1, sat←0, stay in MEASURE.
  - enable=0 in any state → IDLE next cycle, counter←0, sat←0. A pulse in the same cycle is ignored. FIFO contents and overflow are retained.
- Interval semantics: pulses at cycles t0 and t1 produce interval = t1−t0. Back-to-back pulses (t1=t0+1) produce 1.
- FIFO push rule: accepted if count<FIFO_DEPTH, or if full and a pop occurs in the same cycle. Otherwise the sample is dropped and overflow←1.
- Pop: iv_valid && iv_ready advances the head.
- Simultaneous push and pop: count unchanged, order preserved.
- clr_ovf and a new overflow event in the same cycle: overflow ends set (set wins).
- iv_data is held stable while iv_valid && !iv_ready.
- iv_data is don't-care when iv_valid=0; implementation drives the last head value or 0.

## Timing
- Pulse at edge t: entry written at edge t. When FIFO was empty, iv_valid=1 and iv_data is valid from cycle t+1.
- Pop at edge t: next entry, or iv_valid=0, visible from cycle t+1.
- fifo_count updates the cycle after a push or pop; it is fully registered.
- overflow asserts the cycle after the dropped push.
- All outputs are registered; there is no combinational path from pulse_in to any output.
- iv_ready → iv_valid has no combinational dependency. iv_data follows the head pointer only.
- Reset mid-operation: all state clears at that edge regardless of a pending pulse or handshake. A transfer coinciding with rst is void.

## Test plan
- Basic interval: enable=1, pulses at cycles 10, 15, 27, iv_ready=1 → two entries, {0,5} then {0,12}. iv_valid is high one cycle after cycles 15 and 27.
- First pulse and back-to-back: pulses at 3, 4, 5 → entries {0,1}, {0,1}. The pulse at 3 only arms the counter.
- Saturation: CNT_W=4, pulses at 0 and 40 → entry {1,15}. Next pulse at 43 → {0,3}.
- Overflow and backpressure: iv_ready=0, 6 pulses spaced 4 cycles apart, depth 4 → fifo_count=4, overflow=1, first four intervals retained. Raise iv_ready → 4 entries drain in order, then iv_valid=0. A clr_ovf pulse clears the flag.
- Full with simultaneous pop: FIFO full, iv_ready=1 in the same cycle as a pulse → push accepted, count stays 4, overflow stays 0.
- Enable/reset mid-measurement: pulse at 5, enable=0 at 8, enable=1 at 9, pulses at 12 and 20 → single entry {0,8}. Separately, rst at cycle 10 with 2 entries queued → all outputs 0 at cycle 11.
